// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus arbiter: commit op classes,
// payload layout and the per-requester FIFO depth.
package cdb_pkg;

  localparam int CDB_FIFO_DEPTH = 2;

  typedef enum logic [2:0] {
    OP_WRITE   = 3'b000,
    OP_JUMP    = 3'b001,
    OP_BOTH    = 3'b010,
    OP_LS      = 3'b011,
    OP_NOTHING = 3'b100
  } cdb_op_e;

  // Fixed-width part of a result; tag and RS index widths come from the top.
  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [31:0] jump;
  } cdb_body_t;

  // Packed payload is {tag, body, index}.
  function automatic int cdb_payload_w(input int rob_w, input int rs_w);
    return rob_w + $bits(cdb_body_t) + rs_w;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Two-entry result FIFO, one per requester; flush and push/pop act only
// when rdy_in is high.
module cdb_fifo
  import cdb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [CDB_FIFO_DEPTH];
  logic         wr_ptr, rd_ptr;
  logic [1:0]   count;
  logic         do_push, do_pop;

  assign full    = (count == 2'(CDB_FIFO_DEPTH));
  assign empty   = (count == 2'd0);
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full && !flush && rdy_in;
  assign do_pop  = pop && !empty && !flush && rdy_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (rdy_in) begin
      if (flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (do_push) wr_ptr <= ~wr_ptr;
        if (do_pop)  rd_ptr <= ~rd_ptr;
        case ({do_push, do_pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: ;
        endcase
      end
    end
  end

  // Storage carries no reset; count alone says what is valid.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the ROB result-write port among NUM_REQ
// execution units, each buffered by a private 2-entry FIFO.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int ROB_WIDTH = 4,
  parameter int RS_WIDTH  = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          clear,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ROB_WIDTH-1:0]  req_tag,
  input  logic [NUM_REQ*3-1:0]          req_op,
  input  logic [NUM_REQ*5-1:0]          req_rd,
  input  logic [NUM_REQ*32-1:0]         req_wdata,
  input  logic [NUM_REQ*32-1:0]         req_jump,
  input  logic [NUM_REQ*RS_WIDTH-1:0]   req_index,
  output logic                          to_rob,
  output logic [ROB_WIDTH-1:0]          to_rob_tag,
  output logic [2:0]                    to_rob_op,
  output logic [4:0]                    to_rob_rd,
  output logic [31:0]                   to_rob_wdata,
  output logic [31:0]                   to_rob_jump,
  output logic [RS_WIDTH-1:0]           to_rob_index
);

  localparam int PW  = cdb_payload_w(ROB_WIDTH, RS_WIDTH);
  localparam int RRW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]         full, empty, push, pop;
  logic [NUM_REQ-1:0][PW-1:0] din, dout;
  logic [RRW-1:0]             rr_last, winner, idx;
  logic [RRW:0]               sum;
  logic                       grant_vld;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign din[g] = {req_tag[g*ROB_WIDTH +: ROB_WIDTH], req_op[g*3 +: 3],
                     req_rd[g*5 +: 5], req_wdata[g*32 +: 32],
                     req_jump[g*32 +: 32], req_index[g*RS_WIDTH +: RS_WIDTH]};
    // Ready depends only on registered count and the global enable.
    assign req_ready[g] = !full[g] && rdy_in;
    assign push[g]      = req_valid[g] && req_ready[g] && !clear;
    assign pop[g]       = grant_vld && (winner == RRW'(g)) && !clear;

    cdb_fifo #(.W(PW)) u_fifo (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .rdy_in (rdy_in),
      .flush  (clear),
      .push   (push[g]),
      .din    (din[g]),
      .pop    (pop[g]),
      .dout   (dout[g]),
      .full   (full[g]),
      .empty  (empty[g])
    );
  end

  // Scan starts just after the last winner and wraps once around.
  always_comb begin
    grant_vld = 1'b0;
    winner    = '0;
    sum       = '0;
    idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, rr_last} + (RRW+1)'(k);
      if (sum >= (RRW+1)'(NUM_REQ)) sum = sum - (RRW+1)'(NUM_REQ);
      idx = sum[RRW-1:0];
      if (!grant_vld && !empty[idx]) begin
        grant_vld = 1'b1;
        winner    = idx;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      to_rob       <= 1'b0;
      to_rob_tag   <= '0;
      to_rob_op    <= '0;
      to_rob_rd    <= '0;
      to_rob_wdata <= '0;
      to_rob_jump  <= '0;
      to_rob_index <= '0;
      rr_last      <= RRW'(NUM_REQ-1);
    end else if (rdy_in) begin
      if (clear) begin
        to_rob <= 1'b0;
      end else if (grant_vld) begin
        to_rob  <= 1'b1;
        rr_last <= winner;
        {to_rob_tag, to_rob_op, to_rob_rd, to_rob_wdata, to_rob_jump,
         to_rob_index} <= dout[winner];
      end else begin
        to_rob <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scenario bench for cdb_arbiter: expected results are queued in predicted
// grant order and checked as each fresh write strobe appears.
module tb_cdb_arbiter;

  localparam int N = 3;

  typedef struct packed {
    logic [3:0]  tag;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [31:0] jump;
    logic [1:0]  idx;
  } exp_t;

  logic           clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, clear = 1'b0;
  logic [N-1:0]   req_valid = '0, req_ready;
  logic [N*4-1:0] req_tag = '0;
  logic [N*3-1:0] req_op = '0;
  logic [N*5-1:0] req_rd = '0;
  logic [N*32-1:0] req_wdata = '0, req_jump = '0;
  logic [N*2-1:0] req_index = '0;
  logic           to_rob;
  logic [3:0]     to_rob_tag;
  logic [2:0]     to_rob_op;
  logic [4:0]     to_rob_rd;
  logic [31:0]    to_rob_wdata, to_rob_jump;
  logic [1:0]     to_rob_index;

  int   n_checks = 0, n_fail = 0;
  exp_t exp_q[$];
  logic last_edge_rdy = 1'b0;
  exp_t obs;

  cdb_arbiter #(.NUM_REQ(N), .ROB_WIDTH(4), .RS_WIDTH(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .req_op(req_op), .req_rd(req_rd), .req_wdata(req_wdata),
    .req_jump(req_jump), .req_index(req_index), .to_rob(to_rob),
    .to_rob_tag(to_rob_tag), .to_rob_op(to_rob_op), .to_rob_rd(to_rob_rd),
    .to_rob_wdata(to_rob_wdata), .to_rob_jump(to_rob_jump),
    .to_rob_index(to_rob_index)
  );

  always #5 clk_in = ~clk_in;

  assign obs = {to_rob_tag, to_rob_op, to_rob_rd, to_rob_wdata, to_rob_jump, to_rob_index};

  // A strobe is fresh only if the edge that produced it had rdy_in high.
  always @(posedge clk_in) last_edge_rdy <= rdy_in;

  always @(negedge clk_in) begin
    if (!rst_in && to_rob && last_edge_rdy) begin
      exp_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: got tag=%0d payload=%h, required no strobe", to_rob_tag, obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          n_fail++;
          $display("FAIL scoreboard: got tag=%0d payload=%h, required tag=%0d payload=%h",
                   to_rob_tag, obs, e.tag, e);
        end
      end
    end
  end

  function automatic exp_t mk(input int i, input int tag);
    exp_t p;
    p.tag   = 4'(tag);
    p.op    = 3'(tag % 5);
    p.rd    = 5'(tag + 1);
    p.wdata = 32'hC0DE_0000 | 32'(tag << 4) | 32'(i);
    p.jump  = 32'h0000_8000 + 32'(tag * 4);
    p.idx   = 2'(i);
    return p;
  endfunction

  task automatic drive(input int i, input exp_t p);
    req_valid[i]          = 1'b1;
    req_tag[i*4 +: 4]     = p.tag;
    req_op[i*3 +: 3]      = p.op;
    req_rd[i*5 +: 5]      = p.rd;
    req_wdata[i*32 +: 32] = p.wdata;
    req_jump[i*32 +: 32]  = p.jump;
    req_index[i*2 +: 2]   = p.idx;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0; clear = 1'b0; rdy_in = 1'b1; rst_in = 1'b1;
    tick();
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) begin
      @(negedge clk_in);
      #1;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d results still outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (to_rob !== 1'b0 || obs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got to_rob=%b payload=%h, required 0 and 0", to_rob, obs);
    end
    n_checks++;
    if (req_ready !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, required 111", req_ready);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic test_single();
    exp_t p;
    do_reset();
    p = mk(1, 5);
    p.op = 3'b000; p.rd = 5'd3; p.wdata = 32'hDEADBEEF;
    drive(1, p); exp_q.push_back(p);
    tick();
    req_valid = '0;
    @(negedge clk_in);
    n_checks++;
    if (to_rob !== 1'b0) begin
      n_fail++; $display("FAIL single_no_bypass: got to_rob=%b, required 0", to_rob);
    end
    tick(); @(negedge clk_in);
    n_checks++;
    if (to_rob !== 1'b1) begin
      n_fail++; $display("FAIL single_latency: got to_rob=%b, required 1", to_rob);
    end
    tick(); @(negedge clk_in);
    n_checks++;
    if (to_rob !== 1'b0) begin
      n_fail++; $display("FAIL single_one_cycle: got to_rob=%b, required 0", to_rob);
    end
    drain("single", 2);
  endtask

  task automatic test_round_robin();
    logic [3:0] want [3];
    want[0] = 4'd1; want[1] = 4'd2; want[2] = 4'd3;
    do_reset();
    for (int i = 0; i < N; i++) begin
      drive(i, mk(i, i + 1)); exp_q.push_back(mk(i, i + 1));
    end
    tick();
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      tick(); @(negedge clk_in);
      n_checks++;
      if (to_rob !== 1'b1 || to_rob_tag !== want[k]) begin
        n_fail++;
        $display("FAIL rr_order_%0d: got to_rob=%b tag=%0d, required 1 tag=%0d", k, to_rob, to_rob_tag, want[k]);
      end
    end
    // Last winner was 2, so 0 comes before 2.
    drive(0, mk(0, 4)); exp_q.push_back(mk(0, 4));
    drive(2, mk(2, 5)); exp_q.push_back(mk(2, 5));
    tick();
    req_valid = '0;
    drain("rr_second", 6);
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(0, mk(0, 8)); exp_q.push_back(mk(0, 8));
    tick(); req_valid = '0;
    tick();
    drive(1, mk(1, 9));  drive(2, mk(2, 10));
    exp_q.push_back(mk(1, 9)); exp_q.push_back(mk(2, 10));
    exp_q.push_back(mk(0, 11)); exp_q.push_back(mk(1, 13)); exp_q.push_back(mk(0, 12));
    tick(); req_valid = '0;
    drive(0, mk(0, 11));
    tick(); req_valid = '0;
    drive(0, mk(0, 12)); drive(1, mk(1, 13));
    tick(); req_valid = '0;
    @(negedge clk_in);
    n_checks++;
    if (req_ready !== 3'b110) begin
      n_fail++; $display("FAIL bp_full: got req_ready=%b, required 110", req_ready);
    end
    drive(0, mk(0, 14));
    tick(); req_valid = '0;
    @(negedge clk_in);
    n_checks++;
    if (req_ready[0] !== 1'b1 || to_rob_tag !== 4'd11) begin
      n_fail++;
      $display("FAIL bp_pop: got ready0=%b tag=%0d, required 1 tag=11", req_ready[0], to_rob_tag);
    end
    drain("bp", 8);
    repeat (3) tick();
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < N; i++) drive(i, mk(i, i + 1));
    exp_q.push_back(mk(0, 1));
    tick(); req_valid = '0;
    drive(0, mk(0, 4)); drive(1, mk(1, 5));
    tick(); req_valid = '0;
    @(negedge clk_in);
    n_checks++;
    if (req_ready !== 3'b101) begin
      n_fail++; $display("FAIL flush_pre_ready: got %b, required 101", req_ready);
    end
    drive(2, mk(2, 7)); clear = 1'b1;
    tick(); req_valid = '0; clear = 1'b0;
    @(negedge clk_in);
    n_checks++;
    if (to_rob !== 1'b0 || req_ready !== 3'b111) begin
      n_fail++;
      $display("FAIL flush_after: got to_rob=%b ready=%b, required 0 and 111", to_rob, req_ready);
    end
    for (int c = 0; c < 4; c++) begin
      tick(); @(negedge clk_in);
      n_checks++;
      if (to_rob !== 1'b0) begin
        n_fail++; $display("FAIL flush_quiet_%0d: got to_rob=%b, required 0", c, to_rob);
      end
    end
    // Pointer stays at 0 across the flush, so 1 precedes 2.
    drive(1, mk(1, 8)); drive(2, mk(2, 9));
    exp_q.push_back(mk(1, 8)); exp_q.push_back(mk(2, 9));
    tick(); req_valid = '0;
    drain("flush", 6);
  endtask

  task automatic test_stall();
    exp_t p6;
    p6 = mk(0, 6);
    do_reset();
    drive(0, p6); drive(1, mk(1, 8)); drive(2, mk(2, 9));
    exp_q.push_back(p6); exp_q.push_back(mk(1, 8)); exp_q.push_back(mk(2, 9));
    tick(); req_valid = '0;
    tick(); @(negedge clk_in);
    rdy_in = 1'b0;
    drive(0, mk(0, 15));
    for (int c = 0; c < 3; c++) begin
      tick(); @(negedge clk_in);
      n_checks++;
      if (to_rob !== 1'b1 || obs !== p6 || req_ready !== 3'b000) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got to_rob=%b tag=%0d ready=%b, required 1 tag=6 ready=000",
                 c, to_rob, to_rob_tag, req_ready);
      end
    end
    req_valid = '0; rdy_in = 1'b1;
    tick(); @(negedge clk_in);
    n_checks++;
    if (to_rob !== 1'b1 || to_rob_tag !== 4'd8) begin
      n_fail++; $display("FAIL stall_resume: got to_rob=%b tag=%0d, required 1 tag=8", to_rob, to_rob_tag);
    end
    drain("stall", 4);
    repeat (2) tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1, mk(1, 10)); drive(2, mk(2, 11));
    exp_q.push_back(mk(1, 10));
    tick(); req_valid = '0;
    tick(); @(negedge clk_in);
    n_checks++;
    if (to_rob !== 1'b1) begin
      n_fail++; $display("FAIL arst_pre: got to_rob=%b, required 1", to_rob);
    end
    #2 rst_in = 1'b1;
    #1;
    n_checks++;
    if (to_rob !== 1'b0 || obs !== '0) begin
      n_fail++; $display("FAIL arst_immediate: got to_rob=%b payload=%h, required 0 and 0", to_rob, obs);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick(); @(negedge clk_in);
      n_checks++;
      if (to_rob !== 1'b0) begin
        n_fail++; $display("FAIL arst_empty_%0d: got to_rob=%b tag=%0d, required 0", c, to_rob, to_rob_tag);
      end
    end
    drive(0, mk(0, 12)); drive(2, mk(2, 13));
    exp_q.push_back(mk(0, 12)); exp_q.push_back(mk(2, 13));
    tick(); req_valid = '0;
    drain("arst", 6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_stall();
    test_async_reset();
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
